// File: rtl/rdt_pkg.sv
// rtl/rdt_pkg.sv - shared types, constants and nibble-to-key mapping for result_display_tx
// Contents:
//   state_t    : transmit FSM states
//   KEY_ZERO   : key index of the '0' key (reset value of new_key_char)
//   nib_to_key : hex nibble -> keypad key index
package rdt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STROBE = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [3:0] KEY_ZERO = 4'd13;

    // E and F land on the two non-glyph keys: the display still shifts, so
    // digit alignment is preserved even though those glyphs are not drawn.
    function automatic logic [3:0] nib_to_key(input logic [3:0] nibble);
        logic [3:0] k;
        case (nibble)
            4'h1:    k = 4'd0;
            4'h2:    k = 4'd1;
            4'h3:    k = 4'd2;
            4'hA:    k = 4'd3;
            4'h4:    k = 4'd4;
            4'h5:    k = 4'd5;
            4'h6:    k = 4'd6;
            4'hB:    k = 4'd7;
            4'h7:    k = 4'd8;
            4'h8:    k = 4'd9;
            4'h9:    k = 4'd10;
            4'hC:    k = 4'd11;
            4'hD:    k = 4'd15;
            4'hE:    k = 4'd12;
            4'hF:    k = 4'd14;
            default: k = KEY_ZERO;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/nib_to_key_enc.sv
// rtl/nib_to_key_enc.sv - combinational hex nibble to keypad key index encoder
// Ports:
//   nibble : input  [3:0] hex digit
//   key    : output [3:0] keypad key index the display understands
module nib_to_key_enc
    import rdt_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] key
);

    assign key = nib_to_key(nibble);

endmodule

// File: rtl/result_display_tx.sv
// rtl/result_display_tx.sv - replays a 16-bit result as four key events into the shift-left display
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : request a transmission (accepted only in IDLE)
//   value [15:0]  : result word, latched on acceptance
//   busy          : high from accepted start until done
//   done          : one-cycle pulse after the last digit's gap
//   disp_enable   : display accept enable (screen_clear)
//   new_key       : character strobe, display samples on its rising edge
//   new_key_char  : key index of the current digit
// Optional feature: define RDT_AUTO_UPDATE_EN to retransmit automatically
// whenever value differs from the last transmitted word.
module result_display_tx
    import rdt_pkg::*;
#(
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 2,
    parameter int NUM_DIGITS    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic        disp_enable,
    output logic        new_key,
    output logic [3:0]  new_key_char
);

    localparam logic [15:0] STROBE_END = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] GAP_END    = 16'(GAP_CYCLES - 1);
    localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [2:0]  ALL_DIGITS = 3'(NUM_DIGITS);

    state_t      state_q, state_d;
    logic [15:0] value_q, value_d;
    logic [2:0]  digit_q, digit_d;
    logic [15:0] timer_q, timer_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        disp_enable_q, disp_enable_d;
    logic        new_key_q, new_key_d;
    logic [3:0]  char_q, char_d;

    logic        trigger;
    logic [15:0] nib_src;
    logic [2:0]  nib_idx;
    logic [3:0]  nib_sel;
    logic [3:0]  key_next;

`ifdef RDT_AUTO_UPDATE_EN
    logic [15:0] shadow_q, shadow_d;

    assign trigger = start | (value != shadow_q);

    always_comb begin
        shadow_d = shadow_q;
        if (state_q == IDLE && trigger) begin
            shadow_d = value;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= 16'h0000;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign trigger = start;
`endif

    // In IDLE the first nibble comes straight from the input so its key is
    // ready at acceptance; afterwards the encoder looks one digit ahead so
    // the next key is loaded as the current strobe falls.
    always_comb begin
        nib_src = (state_q == IDLE) ? value : value_q;
        nib_idx = (state_q == IDLE) ? 3'd0 : digit_q + 3'd1;
        case (nib_idx)
            3'd0:    nib_sel = nib_src[15:12];
            3'd1:    nib_sel = nib_src[11:8];
            3'd2:    nib_sel = nib_src[7:4];
            default: nib_sel = nib_src[3:0];
        endcase
    end

    nib_to_key_enc u_enc (
        .nibble (nib_sel),
        .key    (key_next)
    );

    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        digit_d       = digit_q;
        timer_d       = timer_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        disp_enable_d = disp_enable_q;
        new_key_d     = new_key_q;
        char_d        = char_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    value_d       = value;
                    busy_d        = 1'b1;
                    disp_enable_d = 1'b1;
                    char_d        = key_next;
                    digit_d       = 3'd0;
                    timer_d       = 16'd0;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                new_key_d = 1'b1;
                timer_d   = 16'd0;
                state_d   = STROBE;
            end
            STROBE: begin
                if (timer_q == STROBE_END) begin
                    new_key_d = 1'b0;
                    timer_d   = 16'd0;
                    digit_d   = digit_q + 3'd1;
                    // The last key stays on the bus once sent.
                    if (digit_q < LAST_DIGIT) begin
                        char_d = key_next;
                    end
                    state_d = GAP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            GAP: begin
                if (timer_q == GAP_END) begin
                    timer_d = 16'd0;
                    if (digit_q < ALL_DIGITS) begin
                        new_key_d = 1'b1;
                        state_d   = STROBE;
                    end else begin
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        disp_enable_d = 1'b0;
                        state_d       = FINISH;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            FINISH: begin
                digit_d = 3'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            value_q       <= 16'h0000;
            digit_q       <= 3'd0;
            timer_q       <= 16'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            disp_enable_q <= 1'b0;
            new_key_q     <= 1'b0;
            char_q        <= KEY_ZERO;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            digit_q       <= digit_d;
            timer_q       <= timer_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            disp_enable_q <= disp_enable_d;
            new_key_q     <= new_key_d;
            char_q        <= char_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign disp_enable  = disp_enable_q;
    assign new_key      = new_key_q;
    assign new_key_char = char_q;

endmodule

// File: tb/tb_result_display_tx.sv
// tb/tb_result_display_tx.sv - scoreboard bench for result_display_tx (default and S=3/G=1 instances)
module tb_result_display_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, start_b;
    logic [15:0] value_a, value_b;
    logic        busy_a, done_a, dis_a, nk_a;
    logic [3:0]  ch_a;
    logic        busy_b, done_b, dis_b, nk_b;
    logic [3:0]  ch_b;

    always #5 clk = ~clk;

    result_display_tx dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start_a),
        .value        (value_a),
        .busy         (busy_a),
        .done         (done_a),
        .disp_enable  (dis_a),
        .new_key      (nk_a),
        .new_key_char (ch_a)
    );

    result_display_tx #(.STROBE_CYCLES(3), .GAP_CYCLES(1), .NUM_DIGITS(4)) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start_b),
        .value        (value_b),
        .busy         (busy_b),
        .done         (done_b),
        .disp_enable  (dis_b),
        .new_key      (nk_b),
        .new_key_char (ch_b)
    );

    typedef struct {
        int ch;
        int rise_at;
    } exp_t;

    exp_t sb[$];
    int   key_of[16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11, 15, 12, 14};
    int   total = 0;
    int   bad = 0;
    int   e = -100;
    int   exp_done = -100;
    int   exp_hi = 1;
    int   ndone = 0;
    int   hi_run = 0;
    bit   sel = 0;
    logic prev_nk = 1'b0;
    logic [3:0] prev_ch = 4'd13;
    logic nk, dn, bs, dis;
    logic [3:0] ch;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic sample();
        nk  = sel ? nk_b   : nk_a;
        ch  = sel ? ch_b   : ch_a;
        dn  = sel ? done_b : done_a;
        bs  = sel ? busy_b : busy_a;
        dis = sel ? dis_b  : dis_a;
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        e++;
        sample();
        if (nk && !prev_nk) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", sb.size(), 1);
            end else begin
                x = sb.pop_front();
                check("char", int'(ch), x.ch);
                check("rise_edge", e, x.rise_at);
                check("char_setup", int'(prev_ch), int'(ch));
            end
        end
        if (nk && prev_nk) check("char_hold", int'(ch), int'(prev_ch));
        if (nk) hi_run++;
        if (!nk && prev_nk) begin
            check("high_len", hi_run, exp_hi);
            hi_run = 0;
        end
        if (dn) begin
            ndone++;
            check("done_edge", e, exp_done);
            check("busy_at_done", int'(bs), 0);
            check("dis_at_done", int'(dis), 0);
        end
        if (e >= 0 && e < exp_done) check("busy", int'(bs), 1);
        prev_nk = nk;
        prev_ch = ch;
    endtask

    task automatic push_tx(input logic [15:0] v, input int s, input int g);
        exp_t x;
        logic [3:0] nib;
        for (int k = 0; k < 4; k++) begin
            nib = v[15 - 4 * k -: 4];
            x.ch = key_of[nib];
            x.rise_at = 1 + k * (s + g);
            sb.push_back(x);
        end
        exp_done = 1 + 4 * (s + g);
        exp_hi = s;
    endtask

    task automatic run_until_done(input int budget);
        int n0;
        int n;
        n0 = ndone;
        n = 0;
        while (ndone == n0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", ndone - n0, 1);
        check("sb_empty", sb.size(), 0);
        exp_done = -100;
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        value_a = 16'h0000;
        value_b = 16'h0000;

        // Reset state
        @(posedge clk);
        #1;
        sample();
        check("rst_busy", int'(bs), 0);
        check("rst_done", int'(dn), 0);
        check("rst_dis", int'(dis), 0);
        check("rst_nk", int'(nk), 0);
        check("rst_char", int'(ch), 13);
        reset_n = 1'b1;
        tick();

        // 3C00 with default timing
        push_tx(16'h3C00, 1, 2);
        value_a = 16'h3C00;
        start_a = 1'b1;
        e = -1;
        tick();
        start_a = 1'b0;
        check("dis_after_start", int'(dis), 1);
        run_until_done(40);
        // start coincident with the done cycle is ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("done_one_cycle", int'(dn), 0);
        repeat (8) tick();
        check("idle_busy", int'(bs), 0);
        check("idle_done_count", ndone, 1);

        // EF5D: non-glyph keys
        push_tx(16'hEF5D, 1, 2);
        value_a = 16'hEF5D;
        start_a = 1'b1;
        e = -1;
        tick();
        start_a = 1'b0;
        run_until_done(40);
        repeat (3) tick();

        // ABCD with an ignored re-start and value change mid-transmission
        push_tx(16'hABCD, 1, 2);
        value_a = 16'hABCD;
        start_a = 1'b1;
        e = -1;
        tick();
        start_a = 1'b0;
        while (e < 4) tick();
        value_a = 16'h1234;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        value_a = 16'hABCD;
        run_until_done(40);
        repeat (10) tick();
        check("single_done", ndone, 3);

        // Reset mid-transmission at edge 6
        push_tx(16'h3C00, 1, 2);
        value_a = 16'h3C00;
        start_a = 1'b1;
        e = -1;
        tick();
        start_a = 1'b0;
        while (e < 6) tick();
        sb.delete();
        reset_n = 1'b0;
        exp_done = -100;
        #1;
        sample();
        check("mid_rst_nk", int'(nk), 0);
        check("mid_rst_busy", int'(bs), 0);
        check("mid_rst_dis", int'(dis), 0);
        check("mid_rst_char", int'(ch), 13);
        value_a = 16'h0000;
        tick();
        tick();
        reset_n = 1'b1;
        hi_run = 0;
        tick();
        push_tx(16'h5678, 1, 2);
        value_a = 16'h5678;
        start_a = 1'b1;
        e = -1;
        tick();
        start_a = 1'b0;
        run_until_done(40);
        repeat (3) tick();

        // STROBE_CYCLES=3, GAP_CYCLES=1 instance
        sel = 1'b1;
        tick();
        push_tx(16'h0001, 3, 1);
        value_b = 16'h0001;
        start_b = 1'b1;
        e = -1;
        tick();
        start_b = 1'b0;
        run_until_done(60);
        repeat (3) tick();
        sel = 1'b0;
        tick();

`ifdef RDT_AUTO_UPDATE_EN
        // Value change alone triggers a transmission, then stays quiet
        push_tx(16'h4400, 1, 2);
        value_a = 16'h4400;
        e = -1;
        tick();
        run_until_done(40);
        repeat (20) tick();
        check("auto_quiet", sb.size(), 0);
        check("auto_done_count", ndone, 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
